// File: rtl/osc_tick_timer_if.sv
// Control and status bundle for osc_tick_timer: divisor load handshake plus
// the divided-clock outputs. The master drives EN/DIV_LD/DIV_VAL.
interface osc_tick_timer_if #(
    parameter int WIDTH = 32'sd16
);
    logic             EN;
    logic             DIV_LD;
    logic [WIDTH-1:0] DIV_VAL;
    logic             DIV_BUSY;
    logic             DIV_ACK;
    logic             CLKO;
    logic             TICK;
    logic [WIDTH-1:0] CNT;

    modport master (
        output EN, DIV_LD, DIV_VAL,
        input  DIV_BUSY, DIV_ACK, CLKO, TICK, CNT
    );

    modport slave (
        input  EN, DIV_LD, DIV_VAL,
        output DIV_BUSY, DIV_ACK, CLKO, TICK, CNT
    );
endinterface

// File: rtl/osc_tick_timer.sv
// Programmable divider on the oscillator clock with glitch-free divisor reload.
// Optional build macro OSC_TICK_GRAY_EN: CNT is presented Gray-coded.
module osc_tick_timer #(
    parameter int WIDTH       = 32'sd16,
    parameter int DIV_DEFAULT = 32'sd4
) (
    input  logic            CLKI,
    input  logic            RSTN,
    osc_tick_timer_if.slave bus
);
    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_t;

    localparam logic [WIDTH-1:0] DIV_RESET =
        (DIV_DEFAULT < 32'sd2) ? WIDTH'(32'd2) : WIDTH'(DIV_DEFAULT);

    // Divisors below 2 cannot produce both a high and a low phase.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        if (d < WIDTH'(32'd2)) r = WIDTH'(32'd2);
        else                   r = d;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] cnt_code(input logic [WIDTH-1:0] b);
`ifdef OSC_TICK_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    hs_state_t        hs_state_r, hs_next_s;
    logic             apply_s, capture_s, wrap_s;
    logic [WIDTH-1:0] cnt_r, div_r, pend_r, cnt_out_r;
    logic [WIDTH-1:0] cnt_next_s, div_next_s;
    logic             run_r, clko_r, tick_r, ack_r;
    logic             clko_next_s, tick_next_s;

    // Handshake state register
    always_ff @(posedge CLKI) begin
        if (!RSTN) hs_state_r <= HS_IDLE;
        else       hs_state_r <= hs_next_s;
    end

    // Handshake next state: one load in flight, ignored requests while busy
    always_comb begin
        hs_next_s = hs_state_r;
        case (hs_state_r)
            HS_IDLE: begin
                if (bus.DIV_LD) hs_next_s = HS_BUSY;
                else            hs_next_s = HS_IDLE;
            end
            HS_BUSY: begin
                if (apply_s) hs_next_s = HS_IDLE;
                else         hs_next_s = HS_BUSY;
            end
            default: hs_next_s = HS_IDLE;
        endcase
    end

    // Handshake outputs: pending value lands at a wrap, or at once when stopped
    always_comb begin
        apply_s   = 1'b0;
        capture_s = 1'b0;
        case (hs_state_r)
            HS_IDLE: capture_s = bus.DIV_LD;
            HS_BUSY: apply_s   = !bus.EN || wrap_s;
            default: begin
                apply_s   = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Next count and divisor; first enabled cycle after a stop shows count 0
    always_comb begin
        wrap_s     = 1'b0;
        cnt_next_s = {WIDTH{1'b0}};
        if (bus.EN && run_r) begin
            if (cnt_r == div_r - WIDTH'(32'd1)) begin
                wrap_s     = 1'b1;
                cnt_next_s = {WIDTH{1'b0}};
            end else begin
                cnt_next_s = cnt_r + WIDTH'(32'd1);
            end
        end else begin
            cnt_next_s = {WIDTH{1'b0}};
        end
        if (apply_s) div_next_s = pend_r;
        else         div_next_s = div_r;
    end

    // Output decode against the divisor that governs the upcoming cycle
    always_comb begin
        clko_next_s = bus.EN && (cnt_next_s < (div_next_s >> 1));
        tick_next_s = bus.EN && (cnt_next_s == div_next_s - WIDTH'(32'd1));
    end

    // Datapath and registered outputs
    always_ff @(posedge CLKI) begin
        if (!RSTN) begin
            cnt_r     <= {WIDTH{1'b0}};
            div_r     <= DIV_RESET;
            pend_r    <= DIV_RESET;
            run_r     <= 1'b0;
            clko_r    <= 1'b0;
            tick_r    <= 1'b0;
            ack_r     <= 1'b0;
            cnt_out_r <= {WIDTH{1'b0}};
        end else begin
            cnt_r     <= cnt_next_s;
            div_r     <= div_next_s;
            run_r     <= bus.EN;
            clko_r    <= clko_next_s;
            tick_r    <= tick_next_s;
            ack_r     <= apply_s;
            cnt_out_r <= cnt_code(cnt_next_s);
            if (capture_s) pend_r <= clamp_div(bus.DIV_VAL);
            else           pend_r <= pend_r;
        end
    end

    assign bus.CNT      = cnt_out_r;
    assign bus.CLKO     = clko_r;
    assign bus.TICK     = tick_r;
    assign bus.DIV_ACK  = ack_r;
    assign bus.DIV_BUSY = (hs_state_r == HS_BUSY);
endmodule

// File: tb/tb_osc_tick_timer.sv
// Directed scoreboard bench for osc_tick_timer; the driver queues expected
// outputs, an independent monitor pops one entry per cycle and compares.
module tb_osc_tick_timer;
    typedef struct packed {
        logic [15:0] cnt;
        logic        clko;
        logic        tick;
        logic        busy;
        logic        ack;
    } exp_t;

    logic  clk;
    logic  rstn;
    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    osc_tick_timer_if #(.WIDTH(16)) bus ();

    osc_tick_timer #(.WIDTH(16), .DIV_DEFAULT(4)) dut (
        .CLKI(clk),
        .RSTN(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_cnt(input logic [15:0] b);
`ifdef OSC_TICK_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h at %0t", nm, fld, act, req, $time);
        end
    endtask

    // One stimulus cycle: inputs plus the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic e, input logic l, input logic [15:0] v,
                       input logic [15:0] c, input logic ck, input logic tk,
                       input logic bz, input logic ak, input string nm);
        exp_t x;
        @(negedge clk);
        rstn       = r;
        bus.EN     = e;
        bus.DIV_LD = l;
        bus.DIV_VAL = v;
        x.cnt  = exp_cnt(c);
        x.clko = ck;
        x.tick = tk;
        x.busy = bz;
        x.ack  = ak;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are sampled just after each rising edge.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "cnt",  bus.CNT,              x.cnt);
                cmp(nm, "clko", {15'd0, bus.CLKO},     {15'd0, x.clko});
                cmp(nm, "tick", {15'd0, bus.TICK},     {15'd0, x.tick});
                cmp(nm, "busy", {15'd0, bus.DIV_BUSY}, {15'd0, x.busy});
                cmp(nm, "ack",  {15'd0, bus.DIV_ACK},  {15'd0, x.ack});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.EN = 1'b0;
        bus.DIV_LD = 1'b0;
        bus.DIV_VAL = 16'd0;

        // reset, then default divisor 4
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst0");
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d4_c0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "d4_c1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "d4_c2");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, "d4_c3");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d4_wrap");

        // odd divisor 5 loaded while stopped
        cyc(1'b1, 1'b0, 1'b1, 16'd5, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, "ld5");
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, "ld5_ack");
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "ld5_idle");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'(i % 5), ((i % 5) < 2), ((i % 5) == 4),
                1'b0, 1'b0, "d5_run");

        // divisor 8, then a reload to 3 requested at count 2
        cyc(1'b1, 1'b0, 1'b1, 16'd8, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, "ld8");
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, "ld8_ack");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d8_c0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "d8_c1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, "d8_c2");
        cyc(1'b1, 1'b1, 1'b1, 16'd3, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0, "chg_c3");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, "chg_c4");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, "chg_c5");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd6, 1'b0, 1'b0, 1'b1, 1'b0, "chg_c6");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd7, 1'b0, 1'b1, 1'b1, 1'b0, "chg_c7");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, "chg_wrap");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, "d3_c1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, "d3_c2");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d3_c0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, "d3_c1b");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, "d3_c2b");

        // load of 0 coinciding with the wrap, second load of 9 while busy
        cyc(1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, "col_wrap");
        cyc(1'b1, 1'b1, 1'b1, 16'd9, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, "col_ign9");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, "col_old");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, "col_apply");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0, "d2_c1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d2_c0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0, "d2_c1b");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "d2_c0b");

        // divisor 1 clamps to the 2 already in force: handshake still completes
        cyc(1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, "ld1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, "ld1_ack");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0, "ld1_c1");

        // reset while a load of 6 is pending
        cyc(1'b1, 1'b1, 1'b1, 16'd6, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, "ld6");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_rst0");
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_rst1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "post_c0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "post_c1");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, "post_c2");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, "post_c3");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "post_wrap");

        // enable drop forces outputs low, re-enable restarts at 0
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "en_off");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, "en_on0");
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, "en_on1");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
